vehiculos_scheduler: RTL and testbench

VEHICULOS_SCHEDULER -- requirements
Module: vehiculos_scheduler

---
 rtl/vehiculos_sched_pkg.sv | 27 ++
 rtl/vehiculos_lane_timer.sv | 39 +++
 rtl/vehiculos_scheduler.sv | 100 ++++++++++
 tb/tb_vehiculos_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vehiculos_sched_pkg.sv
// Shared types and period table for the vehicle lane scheduler.
// VEHICULOS_SCHED_BOOST_EN (top level) selects the halved-period reload path.
package vehiculos_sched_pkg;

  localparam int NLANES = 6;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE
  } vsc_state_e;

  // Entry [n] is the base period in ticks for level n.
  localparam logic [3:0][CNT_W-1:0] BASE_PERIOD = {4'd2, 4'd4, 4'd6, 4'd8};

  function automatic logic [CNT_W-1:0] lane_period(input logic [1:0] lvl,
                                                   input int unsigned lane);
    return BASE_PERIOD[lvl] + CNT_W'(lane >> 1);
  endfunction

  function automatic logic [CNT_W-1:0] boost_period(input logic [CNT_W-1:0] p);
    return (p > CNT_W'(1)) ? (p >> 1) : CNT_W'(1);
  endfunction

endpackage

// File: rtl/vehiculos_lane_timer.sv
// One lane down-counter: reloads on terminal count (1) and emits a one-cycle
// pulse in the following cycle.
module vehiculos_lane_timer
  import vehiculos_sched_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_reload,
  output logic             o_pulse
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (i_load) begin
        r_cnt <= i_reload;
      end else if (i_tick) begin
        if (r_cnt == CNT_W'(1)) begin
          r_cnt   <= i_reload;
          r_pulse <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/vehiculos_scheduler.sv
// Lane shift scheduler: IDLE waits for start | LOAD latches level | RUN counts | PAUSE freezes.
// Define VEHICULOS_SCHED_BOOST_EN to add VSC_BOOST_IN (halved reload periods).
module vehiculos_scheduler #(
  parameter int DATAWIDTH_NVL = 2,
  parameter int NLANES        = vehiculos_sched_pkg::NLANES,
  parameter int PRESCALE      = 50000
) (
  input  logic                     VSC_CLOCK,
  input  logic                     VSC_RESET,
  input  logic                     VSC_START_IN,
  input  logic                     VSC_STOP_IN,
  input  logic                     VSC_PAUSE_IN,
`ifdef VEHICULOS_SCHED_BOOST_EN
  input  logic                     VSC_BOOST_IN,
`endif
  input  logic [DATAWIDTH_NVL-1:0] VSC_NV_IN,
  output logic [DATAWIDTH_NVL-1:0] VSC_NV_OUT,
  output logic                     VSC_CN_OUT,
  output logic [NLANES-1:0]        VSC_SHIFT_OUT,
  output logic                     VSC_BUSY_OUT
);
  import vehiculos_sched_pkg::*;

  localparam int PW = $clog2(PRESCALE);

  vsc_state_e               r_state, w_next;
  logic [PW-1:0]            r_presc;
  logic [DATAWIDTH_NVL-1:0] r_nv, w_lvl;
  logic                     r_cn, r_busy;
  logic                     w_lvl_chg, w_load, w_count, w_tick, w_boost;
  logic [NLANES-1:0]        w_shift;

`ifdef VEHICULOS_SCHED_BOOST_EN
  assign w_boost = VSC_BOOST_IN;
`else
  assign w_boost = 1'b0;
`endif

  assign w_lvl_chg = (VSC_NV_IN != r_nv);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (VSC_START_IN) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_RUN;
      ST_RUN:   if (w_lvl_chg) w_next = ST_LOAD;
                else if (VSC_PAUSE_IN) w_next = ST_PAUSE;
      ST_PAUSE: if (w_lvl_chg) w_next = ST_LOAD;
                else if (!VSC_PAUSE_IN) w_next = ST_RUN;
      default:  w_next = ST_IDLE;
    endcase
    if (VSC_STOP_IN) w_next = ST_IDLE;
  end

  // Count only on edges that stay in or return to RUN, so pausing freezes
  // the schedule for exactly as many cycles as PAUSE_IN is held.
  assign w_load  = (w_next == ST_LOAD);
  assign w_count = ((r_state == ST_RUN) || (r_state == ST_PAUSE)) && (w_next == ST_RUN);
  assign w_tick  = w_count && (r_presc == PW'(PRESCALE - 1));
  assign w_lvl   = w_load ? VSC_NV_IN : r_nv;

  always_ff @(posedge VSC_CLOCK) begin
    if (VSC_RESET) begin
      r_state <= ST_IDLE;
      r_nv    <= '0;
      r_cn    <= 1'b0;
      r_busy  <= 1'b0;
      r_presc <= '0;
    end else begin
      r_state <= w_next;
      r_cn    <= w_load;
      r_busy  <= (w_next != ST_IDLE);
      if (w_load) r_nv <= VSC_NV_IN;
      if (VSC_STOP_IN || w_load) r_presc <= '0;
      else if (w_count) r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    logic [CNT_W-1:0] w_full, w_reload;
    assign w_full   = lane_period(w_lvl, g);
    assign w_reload = w_boost ? boost_period(w_full) : w_full;

    vehiculos_lane_timer u_timer (
      .i_clk    (VSC_CLOCK),
      .i_rst    (VSC_RESET),
      .i_clear  (VSC_STOP_IN),
      .i_load   (w_load),
      .i_tick   (w_tick),
      .i_reload (w_reload),
      .o_pulse  (w_shift[g])
    );
  end

  assign VSC_NV_OUT    = r_nv;
  assign VSC_CN_OUT    = r_cn;
  assign VSC_SHIFT_OUT = w_shift;
  assign VSC_BUSY_OUT  = r_busy;

endmodule

// File: tb/tb_vehiculos_scheduler.sv
// Bench for vehiculos_scheduler: directed scenarios then random stimulus against a
// counting-edge reference model. Boost scenario runs when VEHICULOS_SCHED_BOOST_EN is set.
module tb_vehiculos_scheduler;

  localparam int PS = 4;
  localparam int NL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, stop, pause, boost;
  logic [1:0]    nv_in;
  logic [1:0]    nv_out;
  logic          cn, busy;
  logic [NL-1:0] shift;

  vehiculos_scheduler #(.DATAWIDTH_NVL(2), .NLANES(NL), .PRESCALE(PS)) dut (
    .VSC_CLOCK     (clk),
    .VSC_RESET     (rst),
    .VSC_START_IN  (start),
    .VSC_STOP_IN   (stop),
    .VSC_PAUSE_IN  (pause),
`ifdef VEHICULOS_SCHED_BOOST_EN
    .VSC_BOOST_IN  (boost),
`endif
    .VSC_NV_IN     (nv_in),
    .VSC_NV_OUT    (nv_out),
    .VSC_CN_OUT    (cn),
    .VSC_SHIFT_OUT (shift),
    .VSC_BUSY_OUT  (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: mode 0 idle, 1 load, 2 run, 3 pause; m_n counts active edges since load.
  int m_mode = 0, m_nv = 0, m_n = 0, m_cn = 0, m_busy = 0, m_shift = 0;
  bit m_boost = 1'b0;

  int last_p[NL];
  int intv[NL];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ref_period(input int lvl, input int lane, input bit bst);
    int p;
    p = (8 - 2 * lvl) + lane / 2;
    if (bst) p = (p / 2 < 1) ? 1 : p / 2;
    return p;
  endfunction

  task automatic model_edge();
    int nxt;
    if (rst) begin
      m_mode = 0; m_nv = 0; m_n = 0; m_cn = 0; m_busy = 0; m_shift = 0;
      return;
    end
    nxt = m_mode;
    case (m_mode)
      0: if (start) nxt = 1;
      1: nxt = 2;
      default: begin
        if (int'(nv_in) != m_nv) nxt = 1;
        else if (m_mode == 2 && pause) nxt = 3;
        else if (m_mode == 3 && !pause) nxt = 2;
      end
    endcase
    if (stop) nxt = 0;
    m_shift = 0;
    m_cn = 0;
    if (stop) m_n = 0;
    if (nxt == 1) begin
      m_nv = int'(nv_in); m_cn = 1; m_n = 0; m_boost = boost;
    end
    if ((m_mode == 2 || m_mode == 3) && nxt == 2) begin
      m_n++;
      for (int i = 0; i < NL; i++)
        if (m_n % (ref_period(m_nv, i, m_boost) * PS) == 0) m_shift |= (1 << i);
    end
    m_busy = (nxt != 0) ? 1 : 0;
    m_mode = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("nv_out", int'(nv_out), m_nv);
    chk("cn_out", int'(cn), m_cn);
    chk("shift_out", int'(shift), m_shift);
    chk("busy_out", int'(busy), m_busy);
    for (int i = 0; i < NL; i++)
      if (shift[i]) begin
        if (last_p[i] >= 0) intv[i] = cyc - last_p[i];
        last_p[i] = cyc;
      end
  endtask

  task automatic clear_iv();
    for (int i = 0; i < NL; i++) begin
      last_p[i] = -1;
      intv[i]   = 0;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_pulse(input int lane, input int limit, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      step();
      if (shift[lane]) ok = 1'b1;
    end
    chk(tag, int'(ok), 1);
  endtask

  int load_cyc;

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0; pause = 1'b0; boost = 1'b0; nv_in = 2'd0;
    clear_iv();

    // Reset with start held: nothing moves until reset drops.
    run(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cn", int'(cn), 0);
    chk("rst_shift", int'(shift), 0);
    chk("rst_nv", int'(nv_out), 0);
    rst = 1'b0;
    step();
    chk("post_rst_cn", int'(cn), 1);
    start = 1'b0;
    run(3);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Level 3 start: lanes 0/1 every 8 cycles, lanes 4/5 every 16.
    nv_in = 2'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("l3_cn", int'(cn), 1);
    chk("l3_nv", int'(nv_out), 3);
    load_cyc = cyc;
    wait_pulse(0, 40, "tmo_first_pulse");
    chk("first_pulse_delay", cyc - (load_cyc + 1), 8);
    clear_iv();
    run(40);
    chk("l3_intv0", intv[0], 8);
    chk("l3_intv1", intv[1], 8);
    chk("l3_intv4", intv[4], 16);
    chk("l3_intv5", intv[5], 16);

    // Level change to 0 while running.
    nv_in = 2'd0;
    step();
    chk("l0_cn", int'(cn), 1);
    chk("l0_nv", int'(nv_out), 0);
    step();
    chk("l0_cn_drop", int'(cn), 0);
    clear_iv();
    run(80);
    chk("l0_intv0", intv[0], 32);

    // Pause 10 cycles mid-period stretches the interval by 10.
    clear_iv();
    wait_pulse(0, 40, "tmo_pre_pause");
    run(5);
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("pause_shift", int'(shift), 0);
    end
    pause = 1'b0;
    wait_pulse(0, 60, "tmo_post_pause");
    chk("pause_intv0", intv[0], 42);

    // Stop together with a level change: straight to idle, no load strobe.
    nv_in = 2'd2; stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_cn", int'(cn), 0);
    chk("stop_nv", int'(nv_out), 0);
    run(2);

`ifdef VEHICULOS_SCHED_BOOST_EN
    boost = 1'b1; nv_in = 2'd3; start = 1'b1;
    step();
    start = 1'b0;
    clear_iv();
    wait_pulse(0, 20, "tmo_boost");
    run(20);
    chk("boost_intv0", intv[0], 4);
    stop = 1'b1;
    step();
    stop = 1'b0; boost = 1'b0;
`endif

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      if ($urandom_range(0, 39) == 0) nv_in = 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
